// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder controller: FSM state
//   encodings and the counter-width helper.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  // Bit-slice counter width; never narrower than one bit.
  function automatic int cnt_w(input int width);
    if ($clog2(width) < 1) return 1;
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl_if
//   Request/result handshake bundle of the serial adder controller.
//   master : requester side (drives operands, abort, res_ready)
//   slave  : controller side (drives start_ready, result, busy)
//   Signals: start_valid/start_ready, op_a, op_b, carry_in, abort,
//            res_valid/res_ready, res_sum, res_cout, busy.
// ---------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry_in;
  logic             abort;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             busy;

  modport master (
    output start_valid, op_a, op_b, carry_in, abort, res_ready,
    input  start_ready, res_valid, res_sum, res_cout, busy
  );

  modport slave (
    input  start_valid, op_a, op_b, carry_in, abort, res_ready,
    output start_ready, res_valid, res_sum, res_cout, busy
  );

endinterface

// File: rtl/adder_1bit.sv
// ---------------------------------------------------------------------------
// adder_1bit
//   Single full-adder cell.
//   Ports: input1, input2, carryin (in); sum, carryout (out).
// ---------------------------------------------------------------------------
module adder_1bit (
  input  logic input1,
  input  logic input2,
  input  logic carryin,
  output logic sum,
  output logic carryout
);

  assign sum      = input1 ^ input2 ^ carryin;
  assign carryout = (input1 & input2) | (carryin & (input1 ^ input2));

endmodule

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial WIDTH-bit adder. One adder_1bit cell is reused for WIDTH
//   cycles, LSB first, with the carry registered between slices.
//   Ports:
//     clk   in  system clock, rising edge
//     rst_n in  asynchronous reset, active-low
//     bus   slave modport of serial_adder_ctrl_if (request/result handshakes,
//           abort, busy)
// ---------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_adder_ctrl_if.slave   bus
);

  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             c_r;
  logic [CW-1:0]    cnt;
  logic             cell_sum;
  logic             cell_cout;
  logic             accept;

  // start_ready is exactly "state is IDLE", so this is the request handshake.
  assign accept = (state_q == S_IDLE) && bus.start_valid;

  adder_1bit u_cell (
    .input1   (a_sr[0]),
    .input2   (b_sr[0]),
    .carryin  (c_r),
    .sum      (cell_sum),
    .carryout (cell_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort wins over both the last RUN slice and a DONE result handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start_valid)   state_d = S_RUN;
      S_RUN: begin
        if (bus.abort)               state_d = S_IDLE;
        else if (cnt == LAST)        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.abort)               state_d = S_IDLE;
        else if (bus.res_ready)      state_d = S_IDLE;
      end
      default:                       state_d = S_IDLE;
    endcase
  end

  // Operand and sum shift registers: each RUN cycle consumes bit 0 of the
  // operands and inserts the new sum bit at the top, so after WIDTH slices
  // the first sum bit has travelled down to bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      c_r    <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= bus.op_a;
      b_sr   <= bus.op_b;
      sum_sr <= '0;
      c_r    <= bus.carry_in;
      cnt    <= '0;
    end else if (state_q == S_RUN) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      sum_sr <= {cell_sum, sum_sr[WIDTH-1:1]};
      c_r    <= cell_cout;
      cnt    <= cnt + CW'(1);
    end
  end

  // Outputs decode registered state only; the result is zeroed outside DONE
  // so partially shifted sums never appear on the port.
  always_comb begin
    bus.start_ready = (state_q == S_IDLE);
    bus.busy        = (state_q != S_IDLE);
    bus.res_valid   = (state_q == S_DONE);
    bus.res_sum     = (state_q == S_DONE) ? sum_sr : '0;
    bus.res_cout    = (state_q == S_DONE) && c_r;
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Self-checking bench for serial_adder_ctrl (WIDTH=8). A transaction-level
//   model tracks whether an operation is outstanding and how many edges have
//   passed since it was accepted; the compare process checks every output
//   against it on each falling edge. Directed tests pin literal results.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, actual,
               expected, $time);
    end
  endtask

  // Advance n clock edges; inputs change 1 time unit after the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Behavioural model: an accepted operation produces {cout,sum} = a+b+cin
  // and its result is presented from WIDTH edges after the accept until it
  // is consumed or aborted. Nothing is accepted while one is outstanding.
  bit               m_active = 1'b0;
  int               m_age    = 0;
  logic [WIDTH-1:0] m_sum;
  logic             m_cout;
  bit               exp_valid;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_age    = 0;
    end else begin
      exp_valid = m_active && (m_age >= WIDTH);
      check_output("start_ready", 32'(bus.start_ready), 32'(!m_active));
      check_output("busy", 32'(bus.busy), 32'(m_active));
      check_output("res_valid", 32'(bus.res_valid), 32'(exp_valid));
      if (exp_valid) begin
        check_output("res_sum", 32'(bus.res_sum), 32'(m_sum));
        check_output("res_cout", 32'(bus.res_cout), 32'(m_cout));
      end
      if (!m_active) begin
        if (bus.start_valid) begin
          m_active         = 1'b1;
          m_age            = 0;
          {m_cout, m_sum}  = {1'b0, bus.op_a} + {1'b0, bus.op_b}
                             + (WIDTH + 1)'(bus.carry_in);
        end
      end else if (bus.abort) begin
        m_active = 1'b0;
      end else if (exp_valid && bus.res_ready) begin
        m_active = 1'b0;
      end else begin
        m_age++;
      end
    end
  end

  // Wait (bounded) for the controller to be idle, then issue one operation.
  task automatic apply_stimulus(input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic cin);
    int n = 0;
    while (!bus.start_ready && n < 100) begin
      step(1);
      n++;
    end
    if (!bus.start_ready) check_output("start_ready_timeout", 32'd0, 32'd1);
    bus.op_a        = a;
    bus.op_b        = b;
    bus.carry_in    = cin;
    bus.start_valid = 1'b1;
    step(1);
    bus.start_valid = 1'b0;
  endtask

  // Issue one operation and check its literal result and latency; returns
  // with the result still presented (not yet consumed).
  task automatic run_op(input string name, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic cin,
                        input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
    int n = 0;
    apply_stimulus(a, b, cin);
    while (!bus.res_valid && n < 40) begin
      step(1);
      n++;
    end
    check_output({name, "_latency"}, 32'(n), 32'(WIDTH));
    check_output({name, "_sum"}, 32'(bus.res_sum), 32'(exp_sum));
    check_output({name, "_cout"}, 32'(bus.res_cout), 32'(exp_cout));
  endtask

  initial begin
    int t_acc [4];
    int pulses;
    int accepts;
    int handshakes;
    int guard;
    bit will_accept;

    rst_n           = 1'b0;
    bus.start_valid = 1'b0;
    bus.op_a        = '0;
    bus.op_b        = '0;
    bus.carry_in    = 1'b0;
    bus.abort       = 1'b0;
    bus.res_ready   = 1'b1;
    #1;
    check_output("rst_start_ready", 32'(bus.start_ready), 32'd1);
    check_output("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_output("rst_res_sum", 32'(bus.res_sum), 32'd0);
    check_output("rst_res_cout", 32'(bus.res_cout), 32'd0);
    check_output("rst_busy", 32'(bus.busy), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);

    $display("[TB] basic additions");
    run_op("t1", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
    step(1);
    run_op("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    step(1);
    run_op("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    step(1);
    run_op("t2c", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1);

    $display("[TB] result backpressure");
    bus.res_ready = 1'b0;
    run_op("t3", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);
    bus.start_valid = 1'b1;
    bus.op_a        = 8'hAA;
    bus.op_b        = 8'h55;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check_output("t3_hold_valid", 32'(bus.res_valid), 32'd1);
      check_output("t3_hold_sum", 32'(bus.res_sum), 32'h47);
      check_output("t3_hold_cout", 32'(bus.res_cout), 32'd0);
      check_output("t3_hold_start_ready", 32'(bus.start_ready), 32'd0);
    end
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b1;
    step(1);
    check_output("t3_release_valid", 32'(bus.res_valid), 32'd0);
    check_output("t3_release_ready", 32'(bus.start_ready), 32'd1);

    $display("[TB] back-to-back issue");
    bus.op_a        = 8'h01;
    bus.op_b        = 8'h02;
    bus.carry_in    = 1'b0;
    bus.start_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      guard = 0;
      while (!bus.start_ready && guard < 40) begin
        step(1);
        guard++;
      end
      if (!bus.start_ready) check_output("t4_timeout", 32'd0, 32'd1);
      t_acc[k] = cycle + 1;
      step(1);
      bus.op_a     = 8'(8'h40 * k + 8'h1F);
      bus.op_b     = 8'(8'hC3 - k);
      bus.carry_in = k[0];
    end
    bus.start_valid = 1'b0;
    for (int k = 1; k < 4; k++)
      check_output("t4_interval", 32'(t_acc[k] - t_acc[k-1]), 32'(WIDTH + 2));
    step(12);

    $display("[TB] abort and reset");
    apply_stimulus(8'h77, 8'h11, 1'b1);
    step(2);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    check_output("t5_abort_ready", 32'(bus.start_ready), 32'd1);
    check_output("t5_abort_busy", 32'(bus.busy), 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.res_valid) pulses++;
      step(1);
    end
    check_output("t5_abort_no_valid", 32'(pulses), 32'd0);

    bus.res_ready = 1'b0;
    run_op("t5_done", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    bus.abort     = 1'b1;
    bus.res_ready = 1'b1;
    step(1);
    bus.abort = 1'b0;
    check_output("t5_done_abort_ready", 32'(bus.start_ready), 32'd1);

    apply_stimulus(8'h3C, 8'hC3, 1'b1);
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t5_rst_start_ready", 32'(bus.start_ready), 32'd1);
    check_output("t5_rst_busy", 32'(bus.busy), 32'd0);
    check_output("t5_rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_output("t5_rst_res_sum", 32'(bus.res_sum), 32'd0);
    check_output("t5_rst_res_cout", 32'(bus.res_cout), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1);

    $display("[TB] random traffic");
    accepts         = 0;
    handshakes      = 0;
    guard           = 0;
    bus.start_valid = 1'b0;
    while (accepts < 1000 && guard < 40000) begin
      if (!bus.start_valid) begin
        bus.start_valid = ($urandom_range(0, 3) != 0);
        bus.op_a        = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
        bus.op_b        = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
        bus.carry_in    = 1'($urandom);
      end
      bus.res_ready = ($urandom_range(0, 2) != 0);
      will_accept   = bus.start_valid && bus.start_ready;
      if (bus.res_valid && bus.res_ready) handshakes++;
      step(1);
      guard++;
      if (will_accept) begin
        accepts++;
        bus.start_valid = 1'b0;
      end
    end
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.res_valid && bus.res_ready) handshakes++;
      step(1);
    end
    check_output("t6_accepts", 32'(accepts), 32'd1000);
    check_output("t6_completions", 32'(handshakes), 32'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
